// File: rtl/sum4b_bcd_seq.sv
// sum4b_bcd_seq
// Turns the 5-bit result of an upstream 4-bit adder ({co, zi}, 0..31) into
// two BCD digits. It uses iterative shift-add-3 (double dabble).
// A conversion starts when init is sampled high in IDLE. It takes 11 clocks
// from that edge until the new digits and the done pulse appear.
//
// Ports
//   clk       : single clock, rising edge
//   rst       : synchronous, active-high reset
//   init      : start strobe; ignored while busy
//   co        : upstream carry-out, operand bit 4
//   zi[3:0]   : upstream sum, operand bits 3:0
//   bcd_tens  : tens digit of the last completed conversion (0..3)
//   bcd_units : units digit of the last completed conversion (0..9)
//   busy      : high in every state other than IDLE
//   done      : one-cycle pulse in the cycle the digits update
//
// state | meaning
// IDLE  | waiting for init; operand captured on the accepting edge
// ADD3  | add 3 to every working digit that is >= 5
// SHIFT | shift {bcd, operand} left by one; count down the iterations
// DONE  | publish the working register to the outputs, pulse done

module sum4b_bcd_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       init,
  input  logic       co,
  input  logic [3:0] zi,
  output logic [3:0] bcd_tens,
  output logic [3:0] bcd_units,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD3  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [4:0] shreg;
  logic [7:0] bcd;
  logic [2:0] cnt;
  logic [7:0] bcd_adj;

  // Correct each digit before it is doubled. A digit >= 5 would pass 9 after
  // the shift, so adding 3 first makes the carry land in the next digit.
  always_comb begin
    bcd_adj = bcd;
    if (bcd[3:0] >= 4'd5) bcd_adj[3:0] = bcd[3:0] + 4'd3;
    if (bcd[7:4] >= 4'd5) bcd_adj[7:4] = bcd[7:4] + 4'd3;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (init) state_nxt = ADD3;
      ADD3:    state_nxt = SHIFT;
      SHIFT:   state_nxt = (cnt > 3'd1) ? ADD3 : DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      bcd       <= '0;
      cnt       <= '0;
      bcd_tens  <= '0;
      bcd_units <= '0;
      done      <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (init) begin
            shreg <= {co, zi};
            bcd   <= '0;
            cnt   <= 3'd5;
          end
        end
        ADD3: begin
          bcd <= bcd_adj;
        end
        SHIFT: begin
          // The operand MSB enters the units LSB.
          {bcd, shreg} <= {bcd[6:0], shreg, 1'b0};
          cnt          <= cnt - 3'd1;
        end
        DONE: begin
          bcd_tens  <= bcd[7:4];
          bcd_units <= bcd[3:0];
          done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sum4b_bcd_seq.sv
module tb_sum4b_bcd_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       init;
  logic       co;
  logic [3:0] zi;
  logic [3:0] bcd_tens;
  logic [3:0] bcd_units;
  logic       busy;
  logic       done;

  int checks   = 0;
  int failures = 0;
  int prev_t   = 0;
  int prev_u   = 0;

  typedef struct {
    int v;
    int tens;
    int units;
  } vec_t;

  vec_t vecs[6];

  sum4b_bcd_seq dut (
    .clk       (clk),
    .rst       (rst),
    .init      (init),
    .co        (co),
    .zi        (zi),
    .bcd_tens  (bcd_tens),
    .bcd_units (bcd_units),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: the decimal digits of the operand.
  function automatic int ref_tens(input int v);
    return v / 10;
  endfunction

  function automatic int ref_units(input int v);
    return v % 10;
  endfunction

  // Starts a conversion of v from idle and follows it to completion. While it
  // runs, co/zi are inverted to show that the captured operand alone matters.
  task automatic conv(input int v, input int exp_t, input int exp_u, input string name);
    logic [4:0] vb;
    int busy_cnt;
    int lat;
    bit hold_ok;
    bit got;
    vb = v[4:0];
    init = 1'b1;
    co = vb[4];
    zi = vb[3:0];
    tick();
    init = 1'b0;
    co = ~vb[4];
    zi = ~vb[3:0];
    busy_cnt = 0;
    lat = 0;
    hold_ok = 1'b1;
    got = 1'b0;
    for (int i = 1; i <= 30 && !got; i++) begin
      if (busy === 1'b1) busy_cnt++;
      if (bcd_tens !== prev_t[3:0] || bcd_units !== prev_u[3:0] || done !== 1'b0) hold_ok = 1'b0;
      tick();
      if (done === 1'b1) begin
        got = 1'b1;
        lat = i;
      end
    end
    chk({name, " latency"}, lat, 11);
    chk({name, " busy_cycles"}, busy_cnt, 11);
    chk({name, " busy_in_done"}, {31'd0, busy}, 0);
    chk({name, " tens"}, {28'd0, bcd_tens}, exp_t);
    chk({name, " units"}, {28'd0, bcd_units}, exp_u);
    chk({name, " hold_while_busy"}, {31'd0, hold_ok}, 1);
    prev_t = exp_t;
    prev_u = exp_u;
    tick();
    chk({name, " done_one_cycle"}, {31'd0, done}, 0);
  endtask

  initial begin
    int ndone;
    int last_edge;
    int ok_spacing;
    int ok_busy;
    int ok_val;
    logic [31:0] r;

    vecs[0] = '{0, 0, 0};
    vecs[1] = '{9, 0, 9};
    vecs[2] = '{10, 1, 0};
    vecs[3] = '{19, 1, 9};
    vecs[4] = '{20, 2, 0};
    vecs[5] = '{31, 3, 1};

    rst = 1'b1;
    init = 1'b1;
    co = 1'b1;
    zi = 4'hF;
    tick();
    tick();
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset tens", {28'd0, bcd_tens}, 0);
    chk("reset units", {28'd0, bcd_units}, 0);
    rst = 1'b0;
    init = 1'b0;
    tick();
    chk("idle no start", {31'd0, busy}, 0);

    conv(0, 0, 0, "zero");

    foreach (vecs[i])
      conv(vecs[i].v, vecs[i].tens, vecs[i].units, $sformatf("vec%0d", vecs[i].v));

    for (int v = 0; v < 32; v++)
      conv(v, ref_tens(v), ref_units(v), $sformatf("sweep%0d", v));

    for (int k = 0; k < 16; k++) begin
      r = $urandom_range(31);
      conv(int'(r), ref_tens(int'(r)), ref_units(int'(r)), $sformatf("rand%0d", r));
    end

    // init pulsed mid-conversion with a different operand is ignored.
    init = 1'b1;
    co = 1'b1;
    zi = 4'd9;
    tick();
    init = 1'b0;
    ndone = 0;
    ok_val = 1;
    for (int i = 1; i <= 40; i++) begin
      if (i == 4) begin
        init = 1'b1;
        co = 1'b0;
        zi = 4'd7;
      end else begin
        init = 1'b0;
      end
      tick();
      if (done === 1'b1) begin
        ndone++;
        if (bcd_tens !== 4'd2 || bcd_units !== 4'd5) ok_val = 0;
      end
    end
    chk("ignore_init done_count", ndone, 1);
    chk("ignore_init result_25", ok_val, 1);
    prev_t = 2;
    prev_u = 5;

    // Reset in the middle of a conversion aborts it and clears the outputs.
    conv(31, 3, 1, "pre_abort31");
    init = 1'b1;
    co = 1'b0;
    zi = 4'd12;
    tick();
    init = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", {31'd0, busy}, 0);
    chk("abort tens", {28'd0, bcd_tens}, 0);
    chk("abort units", {28'd0, bcd_units}, 0);
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    chk("abort no_done", ndone, 0);
    prev_t = 0;
    prev_u = 0;
    conv(12, 1, 2, "after_abort12");

    // init held high with 17: a new conversion starts on every idle cycle,
    // so each period is one idle cycle plus eleven busy ones.
    init = 1'b1;
    co = 1'b1;
    zi = 4'd1;
    ndone = 0;
    last_edge = -1;
    ok_spacing = 1;
    ok_busy = 1;
    ok_val = 1;
    for (int i = 1; i <= 62; i++) begin
      tick();
      if (done === 1'b1) begin
        ndone++;
        if (bcd_tens !== 4'd1 || bcd_units !== 4'd7) ok_val = 0;
        if (last_edge >= 0 && (i - last_edge) != 12) ok_spacing = 0;
        last_edge = i;
      end
      if (last_edge >= 0 && busy !== ~done) ok_busy = 0;
    end
    chk("held_init done_count", ndone, 5);
    chk("held_init spacing", ok_spacing, 1);
    chk("held_init busy_low_only_in_done", ok_busy, 1);
    chk("held_init result_17", ok_val, 1);
    init = 1'b0;

    // rst and init together: reset wins and nothing starts.
    rst = 1'b1;
    init = 1'b1;
    tick();
    rst = 1'b0;
    init = 1'b0;
    chk("rst_init busy", {31'd0, busy}, 0);
    chk("rst_init tens", {28'd0, bcd_tens}, 0);
    tick();
    chk("rst_init still_idle", {31'd0, busy}, 0);
    chk("rst_init no_done", {31'd0, done}, 0);
    prev_t = 0;
    prev_u = 0;
    conv(27, 2, 7, "first_after_rst27");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
